// File: rtl/ram_nrw_pkg.sv
// Shared types for the N-port byte-mask RAM: port index, init FSM states and
// the per-byte write-priority rule used by both the RAM and its checker.
package ram_nrw_pkg;

   localparam int max_ports_lp = 4;

   typedef logic [1:0] port_idx_t;

   typedef enum logic {INIT, RUN} state_e;

   // The highest-index port with its byte enable set owns the byte.
   function automatic port_idx_t byte_winner(input logic [max_ports_lp-1:0] hits);
      port_idx_t win;
      win = '0;
      for (int q = 0; q < max_ports_lp; q++) begin
         if (hits[q]) win = port_idx_t'(q);
      end
      return win;
   endfunction

endpackage

// File: rtl/ram_nrw_fwd_merge.sv
// Per-port post-write view of one entry: same-cycle writes overlaid on the array word.
// Purely combinational, no backpressure; also flags overlapping same-address writes.
module ram_nrw_fwd_merge
   import ram_nrw_pkg::*;
#(
   parameter int width_p      = 64,
   parameter int addr_width_p = 6,
   parameter int ports_p      = 2
) (
   input  logic [addr_width_p-1:0]         addr_i,
   input  logic [width_p-1:0]              mem_data_i,
   input  logic [ports_p-1:0]              wr_v_i,
   input  logic [ports_p*addr_width_p-1:0] wr_addr_i,
   input  logic [ports_p*width_p-1:0]      wr_data_i,
   input  logic [ports_p*(width_p/8)-1:0]  wr_mask_i,
   output logic [width_p-1:0]              data_o,
   output logic                            collision_o
);

   localparam int mask_width_lp = width_p / 8;

   always_comb begin
      logic [max_ports_lp-1:0] hits;
      logic                    seen;
      int                      win;
      data_o      = mem_data_i;
      collision_o = 1'b0;
      hits        = '0;
      seen        = 1'b0;
      win         = 0;
      for (int b = 0; b < mask_width_lp; b++) begin
         hits = '0;
         seen = 1'b0;
         for (int q = 0; q < ports_p; q++) begin
            hits[q] = wr_v_i[q]
                      && (wr_addr_i[q*addr_width_p +: addr_width_p] == addr_i)
                      && wr_mask_i[q*mask_width_lp + b];
            if (hits[q] && seen) collision_o = 1'b1;
            seen = seen | hits[q];
         end
         if (seen) begin
            win = int'(byte_winner(hits));
            data_o[b*8 +: 8] = wr_data_i[win*width_p + b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/ram_nrw_byte_mask_sync.sv
// N-port byte-mask RAM, write-first forwarding, read latency 1 (+1 with out_reg_p); ready_o gates all ports.
// RAM_NRW_ZERO_INIT_EN: zero every entry after reset (els_p cycles, ready_o low) before accepting accesses.
module ram_nrw_byte_mask_sync
   import ram_nrw_pkg::*;
#(
   parameter int  width_p       = 64,
   parameter int  els_p         = 64,
   parameter int  ports_p       = 2,
   parameter int  out_reg_p     = 0,
   localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int mask_width_lp = width_p / 8
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [ports_p-1:0]               v_i,
   input  logic [ports_p-1:0]               w_i,
   input  logic [ports_p*addr_width_lp-1:0] addr_i,
   input  logic [ports_p*width_p-1:0]       data_i,
   input  logic [ports_p*mask_width_lp-1:0] mask_i,
   output logic                             ready_o,
   output logic [ports_p-1:0]               r_v_o,
   output logic [ports_p*width_p-1:0]       r_data_o,
   output logic                             collision_o
);

   localparam logic [addr_width_lp:0] els_lp = (addr_width_lp+1)'(els_p);

   logic                       ready;
   logic [ports_p-1:0]         acc_v;
   logic [ports_p-1:0]         in_range;
   logic [ports_p-1:0]         wr_v;
   logic [ports_p-1:0]         coll_vec;
   logic [ports_p*width_p-1:0] mem_rd;
   logic [ports_p*width_p-1:0] merged;
   logic [width_p-1:0]         mem [els_p];

   logic [ports_p-1:0]         rv1_q, rv1_d;
   logic [ports_p*width_p-1:0] rd1_q, rd1_d;
   logic                       coll1_q, coll1_d;

`ifdef RAM_NRW_ZERO_INIT_EN
   state_e                   state_q;
   logic [addr_width_lp-1:0] init_cnt_q;
   logic                     ready_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         ready_q    <= 1'b0;
      end else if (state_q == INIT) begin
         if (init_cnt_q == addr_width_lp'(els_p - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
         end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
         end
      end
   end

   assign ready = ready_q;
`else
   assign ready = 1'b1;
`endif

   assign ready_o = ready;
   assign acc_v   = v_i & {ports_p{ready}};
   assign wr_v    = acc_v & w_i & in_range;

   // Out-of-range addresses read as zero rather than X from the array.
   always_comb begin
      in_range = '0;
      mem_rd   = '0;
      for (int p = 0; p < ports_p; p++) begin
         in_range[p] = {1'b0, addr_i[p*addr_width_lp +: addr_width_lp]} < els_lp;
         if (in_range[p]) begin
            mem_rd[p*width_p +: width_p] = mem[addr_i[p*addr_width_lp +: addr_width_lp]];
         end
      end
   end

   for (genvar p = 0; p < ports_p; p++) begin : g_port
      ram_nrw_fwd_merge #(
         .width_p     (width_p),
         .addr_width_p(addr_width_lp),
         .ports_p     (ports_p)
      ) u_merge (
         .addr_i     (addr_i[p*addr_width_lp +: addr_width_lp]),
         .mem_data_i (mem_rd[p*width_p +: width_p]),
         .wr_v_i     (wr_v),
         .wr_addr_i  (addr_i),
         .wr_data_i  (data_i),
         .wr_mask_i  (mask_i),
         .data_o     (merged[p*width_p +: width_p]),
         .collision_o(coll_vec[p])
      );

      a_addr_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
         !(acc_v[p] && !in_range[p]));
   end

   // A writer's merged word already is the committed entry, so co-addressed writers agree.
   always_ff @(posedge clk_i) begin
`ifdef RAM_NRW_ZERO_INIT_EN
      if (state_q == INIT) mem[init_cnt_q] <= '0;
`endif
      for (int p = 0; p < ports_p; p++) begin
         if (wr_v[p]) mem[addr_i[p*addr_width_lp +: addr_width_lp]] <= merged[p*width_p +: width_p];
      end
   end

   always_comb begin
      rv1_d   = acc_v;
      rd1_d   = rd1_q;
      coll1_d = |coll_vec;
      for (int p = 0; p < ports_p; p++) begin
         if (acc_v[p]) rd1_d[p*width_p +: width_p] = merged[p*width_p +: width_p];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rv1_q   <= '0;
         rd1_q   <= '0;
         coll1_q <= 1'b0;
      end else begin
         rv1_q   <= rv1_d;
         rd1_q   <= rd1_d;
         coll1_q <= coll1_d;
      end
   end

   if (out_reg_p != 0) begin : g_out_reg
      logic [ports_p-1:0]         rv2_q, rv2_d;
      logic [ports_p*width_p-1:0] rd2_q, rd2_d;
      logic                       coll2_q, coll2_d;

      always_comb begin
         rv2_d   = rv1_q;
         rd2_d   = rd1_q;
         coll2_d = coll1_q;
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            rv2_q   <= '0;
            rd2_q   <= '0;
            coll2_q <= 1'b0;
         end else begin
            rv2_q   <= rv2_d;
            rd2_q   <= rd2_d;
            coll2_q <= coll2_d;
         end
      end

      assign r_v_o       = rv2_q;
      assign r_data_o    = rd2_q;
      assign collision_o = coll2_q;
   end else begin : g_no_out_reg
      assign r_v_o       = rv1_q;
      assign r_data_o    = rd1_q;
      assign collision_o = coll1_q;
   end

endmodule

// File: tb/tb_ram_nrw_byte_mask_sync.sv
// Bench: two RAM instances (latency 1 and 2) driven in lockstep, checked against an array model.
module tb_ram_nrw_byte_mask_sync;

   localparam int W  = 32;
   localparam int E  = 16;
   localparam int P  = 2;
   localparam int AW = 4;
   localparam int MW = 4;
`ifdef RAM_NRW_ZERO_INIT_EN
   localparam logic RDY_RST = 1'b0;
`else
   localparam logic RDY_RST = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst_n, rst2_n;
   logic [1:0]  t_v, t_w;
   logic [3:0]  t_a [2];
   logic [31:0] t_d [2];
   logic [3:0]  t_m [2];

   logic [P*AW-1:0] addr_bus;
   logic [P*W-1:0]  data_bus;
   logic [P*MW-1:0] mask_bus;
   assign addr_bus = {t_a[1], t_a[0]};
   assign data_bus = {t_d[1], t_d[0]};
   assign mask_bus = {t_m[1], t_m[0]};

   logic        ready0, coll0, ready2, coll2;
   logic [1:0]  rv0, rv2;
   logic [63:0] rd0, rd2;

   logic [31:0] mm [E];
   logic [1:0]  e_rv, p_rv;
   logic [31:0] e_rd [2];
   logic [31:0] p_rd [2];
   logic        e_coll, p_coll;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ram_nrw_byte_mask_sync #(.width_p(W), .els_p(E), .ports_p(P), .out_reg_p(0)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(t_v), .w_i(t_w), .addr_i(addr_bus),
      .data_i(data_bus), .mask_i(mask_bus), .ready_o(ready0), .r_v_o(rv0),
      .r_data_o(rd0), .collision_o(coll0));

   ram_nrw_byte_mask_sync #(.width_p(W), .els_p(E), .ports_p(P), .out_reg_p(1)) dut2 (
      .clk_i(clk), .reset_n_i(rst2_n), .v_i(t_v), .w_i(t_w), .addr_i(addr_bus),
      .data_i(data_bus), .mask_i(mask_bus), .ready_o(ready2), .r_v_o(rv2),
      .r_data_o(rd2), .collision_o(coll2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] w,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] m0, input logic [3:0] m1);
      t_v = v; t_w = w;
      t_a[0] = a0; t_a[1] = a1;
      t_d[0] = d0; t_d[1] = d1;
      t_m[0] = m0; t_m[1] = m1;
   endtask

   // Apply writes port by port (later port overwrites), then read the new array.
   task automatic step(input string tag);
      logic [31:0] nm [E];
      p_rv = e_rv; p_rd = e_rd; p_coll = e_coll;
      nm = mm;
      for (int p = 0; p < P; p++)
         if (t_v[p] && t_w[p])
            for (int b = 0; b < MW; b++)
               if (t_m[p][b]) nm[t_a[p]][8*b +: 8] = t_d[p][8*b +: 8];
      e_coll = (t_v == 2'b11) && (t_w == 2'b11) && (t_a[0] == t_a[1]) && ((t_m[0] & t_m[1]) != 4'h0);
      for (int p = 0; p < P; p++) begin
         e_rv[p] = t_v[p];
         if (t_v[p]) e_rd[p] = nm[t_a[p]];
      end
      mm = nm;
      @(posedge clk); #1;
      check({tag, "_ready"}, ready0, 1);
      check({tag, "_rv"}, rv0, e_rv);
      check({tag, "_rd0"}, rd0[31:0], e_rd[0]);
      check({tag, "_rd1"}, rd0[63:32], e_rd[1]);
      check({tag, "_coll"}, coll0, e_coll);
      check({tag, "_l2_ready"}, ready2, 1);
      check({tag, "_l2_rv"}, rv2, p_rv);
      check({tag, "_l2_rd0"}, rd2[31:0], p_rd[0]);
      check({tag, "_l2_rd1"}, rd2[63:32], p_rd[1]);
      check({tag, "_l2_coll"}, coll2, p_coll);
   endtask

   initial begin
      logic [3:0] a0, a1;
      rst_n = 1'b0; rst2_n = 1'b0;
      drive(2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      e_rv = '0; e_rd[0] = '0; e_rd[1] = '0; e_coll = 1'b0;
      p_rv = '0; p_rd[0] = '0; p_rd[1] = '0; p_coll = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready0, RDY_RST);
      check("rst_rv", rv0, 0);
      check("rst_rd", rd0[31:0], 0);
      check("rst_coll", coll0, 0);
      check("rst_l2_rv", rv2, 0);
      check("rst_l2_rd", rd2[63:32], 0);
      @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;

`ifdef RAM_NRW_ZERO_INIT_EN
      for (int i = 0; i < E; i++) mm[i] = '0;
      #1 check("init_ready_lo", ready0, 0);
      for (int i = 1; i < E; i++) begin
         @(posedge clk); #1;
         check("init_ready_lo", ready0, 0);
      end
      @(posedge clk); #1;
      check("init_ready_hi", ready0, 1);
      for (int i = 0; i < E/2; i++) begin
         drive(2'b11, 2'b00, 4'(i), 4'(E-1-i), 32'h0, 32'h0, 4'h0, 4'h0);
         step("init_zero");
         check("init_zero_lo", rd0[31:0], 0);
         check("init_zero_hi", rd0[63:32], 0);
      end
`endif

      for (int i = 0; i < E/2; i++) begin
         drive(2'b11, 2'b11, 4'(i), 4'(i + E/2), 32'h0, 32'h0, 4'hF, 4'hF);
         step("fill");
      end

      drive(2'b01, 2'b01, 4'd3, 4'd0, 32'hAABBCCDD, 32'h0, 4'hF, 4'h0);
      step("t1_wr");
      drive(2'b10, 2'b00, 4'd0, 4'd3, 32'h0, 32'h0, 4'h0, 4'h0);
      step("t1_rd");
      check("t1_rv1", rv0[1], 1);
      check("t1_rd1", rd0[63:32], 32'hAABBCCDD);

      drive(2'b01, 2'b01, 4'd5, 4'd0, 32'h11223344, 32'h0, 4'hF, 4'h0);
      step("t2_wr");
      drive(2'b11, 2'b10, 4'd5, 4'd5, 32'h0, 32'hFFEEDDCC, 4'h0, 4'h3);
      step("t2_fwd");
      check("t2_fwd_rd0", rd0[31:0], 32'h1122DDCC);
      check("t2_fwd_coll", coll0, 0);

      drive(2'b11, 2'b11, 4'd7, 4'd7, 32'h000000AA, 32'h0000BB00, 4'h1, 4'h3);
      step("t3_ww");
      check("t3_coll", coll0, 1);
      check("t3_rd0", rd0[31:0], 32'h0000BB00);
      drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      step("t3_idle");
      check("t3_coll_drop", coll0, 0);
      drive(2'b01, 2'b00, 4'd7, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      step("t3_rd");
      check("t3_entry7", rd0[31:0], 32'h0000BB00);

      drive(2'b11, 2'b11, 4'd9, 4'd9, 32'h12345678, 32'h9ABCDEF0, 4'hC, 4'h3);
      step("t4_merge");
      check("t4_coll", coll0, 0);
      check("t4_rd1", rd0[63:32], 32'h1234DEF0);

      drive(2'b01, 2'b01, 4'd3, 4'd0, 32'hFFFFFFFF, 32'h0, 4'h0, 4'h0);
      step("t5_nomask");
      check("t5_rd0", rd0[31:0], 32'hAABBCCDD);

      for (int i = 0; i < 400; i++) begin
         a0 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
         a1 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
         drive(2'($urandom), 2'($urandom), a0, a1, $urandom, $urandom, 4'($urandom), 4'($urandom));
         step("rnd");
      end

      drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      step("lat_idle");
      step("lat_idle");
      drive(2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      step("lat_c0");
      check("lat_c1_rv", rv2, 0);
      drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      step("lat_c1");
      check("lat_c2_rv", rv2, 2'b01);
      step("lat_c2");
      check("lat_c3_rv", rv2, 0);

      drive(2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      step("rmid_c0");
      drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0);
      rst2_n = 1'b0;
      @(posedge clk); #1;
      check("rmid_rv", rv2, 0);
      @(negedge clk);
      rst2_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rmid_after_rv", rv2, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/ram_nrw_byte_mask_sync.md
Name: ram_nrw_byte_mask_sync

Overview:
- Parametrised N-port synchronous RAM. Every port can read or write, and writes use a byte mask.
- It generalises the team's 2-port byte-mask RAM to a configurable port count, with defined collision behaviour.
- Read-during-write on any port pair returns forwarded (write-first) data. Write-write collisions are resolved by fixed per-byte priority and reported.
- Used as tag/data/state storage in the cache and NoC buffer blocks.

Parameters:
- width_p, 64, data width in bits; must be a multiple of 8.
- els_p, 64, number of entries; must be at least 2.
- ports_p, 2, number of read/write ports, 1..4.
- out_reg_p, 0, 1 adds an output register stage, making read latency 2.
- addr_width_lp, clog2(els_p) (safe clog2), address width; local.
- mask_width_lp, width_p/8, byte-mask width; local.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  ports_p  per-port access valid.
- w_i  in  ports_p  per-port write (1) or read (0); qualified by v_i.
- addr_i  in  ports_p*addr_width_lp  per-port address.
- data_i  in  ports_p*width_p  per-port write data.
- mask_i  in  ports_p*mask_width_lp  per-port byte write enables.
- ready_o  out  1  array accepts accesses.
- r_v_o  out  ports_p  per-port read data valid.
- r_data_o  out  ports_p*width_p  per-port read data.
- collision_o  out  1  pulse: write-write same-address byte overlap occurred.

Behaviour:
- Reset (reset_n_i low, asynchronous): r_v_o=0, r_data_o=0, collision_o=0, output pipe cleared, ready_o=1. Array contents are not reset, except under the optional feature.
- Accesses with ready_o=0 are ignored: no write, no r_v_o.
- Write: on the clk_i edge with v_i[p]&w_i[p], byte b of entry addr_i[p] takes data_i[p] byte b where mask_i[p][b]=1. Other bytes hold. Mask all-zero is a legal no-op write.
- Read latency out_reg_p=0: r_v_o[p]=1 one cycle after v_i[p]&~w_i[p]; r_data_o[p] is the entry value after all same-cycle writes commit.
- Read latency out_reg_p=1: two cycles; second stage is a plain register copy. r_v_o and r_data_o move together.
- A writing port also returns data: r_v_o[p]=1 with the post-write entry (write-first).
- Cross-port forwarding: a read on port p and a write on port q≠p to the same address in the same cycle forward the written bytes; unmasked bytes come from the array. Never undefined.
- Write-write, same address: per byte, the highest-index port with its mask bit set wins.
- collision_o=1 for exactly one cycle, aligned with that cycle's read data, iff two or more writing ports share an address and their masks overlap in any byte. Disjoint masks merge cleanly with no flag.
- r_data_o holds its last value when r_v_o=0; it is not zeroed after reset release.
- Out-of-range address (addr ≥ els_p when els_p is not a power of 2): write dropped, read returns 0. Simulation-only error.
- Reset asserted mid-read: pending r_v_o are dropped and never emitted after release.

Optional Feature:
- Macro RAM_NRW_ZERO_INIT_EN.
- Defined: reset enters state INIT. A counter walks entries 0..els_p-1, writing zero one entry per cycle, with ready_o=0. After the last entry the block moves to RUN with ready_o=1. Total init is els_p cycles after reset release. Reset during INIT restarts the count at 0.
- Not defined: there is no FSM, ready_o is tied to 1, and array contents are X until written.

Decomposition:
- Package ram_nrw_pkg holds:
  - the port-index type;
  - the state enum {INIT, RUN};
  - a function for per-byte winner selection, shared with the checker.
- Sub-module ram_nrw_fwd_merge computes, per port, the merged read word and the collision bit. It is combinational and instantiated once per port.
- Top level holds the array, the write-commit logic, the output pipe and the init FSM.

Test Plan:
- width 32, els 16, ports 2: P0 write addr 3 data 0xAABBCCDD mask 0xF, next cycle P1 read addr 3 -> next cycle r_v_o[1]=1, r_data_o[1]=0xAABBCCDD.
- Same cycle: P0 read addr 5 (holding 0x11223344), P1 write addr 5 data 0xFFEEDDCC mask 0x3 -> r_data_o[0]=0x1122DDCC, collision_o=0.
- P0 write addr 7 0x000000AA mask 0x1, P1 write addr 7 0x0000BB00 mask 0x3, same cycle -> entry 7 = 0x0000BB00, collision_o pulses once.
- P0/P1 write addr 9 with masks 0xC and 0x3 -> clean merge, collision_o=0.
- out_reg_p=1: read issued cycle 0 -> r_v_o high cycle 2 only; reset asserted in cycle 1 -> no r_v_o after release.
- RAM_NRW_ZERO_INIT_EN, els 16: ready_o low for 16 cycles after release; read of every address returns 0.
